// File: rtl/aes_key_expand_ctrl.sv
// AES-128 key schedule sequencer sharing one external SubWord unit; streams rk0..rk10.
// Optional round-key store with read port: define AES_KEY_EXP_STORE_EN.
module aes_key_expand_ctrl #(
  parameter int SB_LAT = 0,
  parameter int NR     = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         sb_start,
  output logic [31:0]  sb_w,
  input  logic [31:0]  sb_wi,
  output logic         rk_valid,
  output logic [3:0]   rk_idx,
  output logic [127:0] rk_data,
  output logic         done
`ifdef AES_KEY_EXP_STORE_EN
  ,
  input  logic [3:0]   rk_rd_idx,
  output logic [127:0] rk_rd_data
`endif
);

  // state | meaning
  // IDLE  | waiting for key_valid
  // SUB   | SubWord request issued (sb_start high)
  // WAIT  | SubWord latency, request held
  // ROUND | compute next round key from sb_q
  // FIN   | done pulse, busy still high; key_valid ignored here
  typedef enum logic [2:0] {IDLE, SUB, WAIT, ROUND, FIN} state_t;

  localparam logic [1:0] CNT_LAST = (SB_LAT == 0) ? 2'd0 : 2'(SB_LAT - 1);
  localparam logic [3:0] LAST_RND = 4'(NR);

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  state_t        state, state_nxt;
  logic [127:0]  w, w_nxt;
  logic [3:0]    round, round_nxt;
  logic [7:0]    rcon, rcon_nxt;
  logic [1:0]    cnt, cnt_nxt;
  logic [31:0]   sb_q, sb_q_nxt;
  logic          busy_nxt, sb_start_nxt, rk_valid_nxt, done_nxt;
  logic [31:0]   sb_w_nxt;
  logic [3:0]    rk_idx_nxt;
  logic [127:0]  rk_data_nxt;

  logic [31:0]   t, w0n, w1n, w2n, w3n;
  logic [3:0]    round_inc;
  logic [7:0]    rcon_x;

  assign t         = sb_q ^ {rcon, 24'h0};
  assign w0n       = w[127:96] ^ t;
  assign w1n       = w[95:64] ^ w0n;
  assign w2n       = w[63:32] ^ w1n;
  assign w3n       = w[31:0] ^ w2n;
  assign round_inc = round + 4'd1;
  assign rcon_x    = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

  always_comb begin
    state_nxt    = state;
    w_nxt        = w;
    round_nxt    = round;
    rcon_nxt     = rcon;
    cnt_nxt      = cnt;
    sb_q_nxt     = sb_q;
    busy_nxt     = busy;
    sb_start_nxt = 1'b0;
    sb_w_nxt     = sb_w;
    rk_valid_nxt = 1'b0;
    rk_idx_nxt   = rk_idx;
    rk_data_nxt  = rk_data;
    done_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (key_valid) begin
          w_nxt        = key_in;
          rk_valid_nxt = 1'b1;
          rk_idx_nxt   = 4'd0;
          rk_data_nxt  = key_in;
          busy_nxt     = 1'b1;
          rcon_nxt     = 8'h01;
          round_nxt    = 4'd0;
          sb_start_nxt = 1'b1;
          sb_w_nxt     = rot_word(key_in[31:0]);
          state_nxt    = SUB;
        end
      end
      SUB: begin
        if (SB_LAT == 0) begin
          sb_q_nxt  = sb_wi;
          state_nxt = ROUND;
        end else begin
          sb_start_nxt = 1'b1;
          cnt_nxt      = 2'd0;
          state_nxt    = WAIT;
        end
      end
      WAIT: begin
        if (cnt == CNT_LAST) begin
          sb_q_nxt  = sb_wi;
          state_nxt = ROUND;
        end else begin
          sb_start_nxt = 1'b1;
          cnt_nxt      = cnt + 2'd1;
        end
      end
      ROUND: begin
        w_nxt        = {w0n, w1n, w2n, w3n};
        round_nxt    = round_inc;
        rk_valid_nxt = 1'b1;
        rk_idx_nxt   = round_inc;
        rk_data_nxt  = {w0n, w1n, w2n, w3n};
        rcon_nxt     = rcon_x;
        if (round_inc == LAST_RND) begin
          done_nxt  = 1'b1;
          state_nxt = FIN;
        end else begin
          sb_start_nxt = 1'b1;
          sb_w_nxt     = rot_word(w3n);
          state_nxt    = SUB;
        end
      end
      FIN: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      w        <= '0;
      round    <= '0;
      rcon     <= 8'h01;
      cnt      <= '0;
      sb_q     <= '0;
      busy     <= 1'b0;
      sb_start <= 1'b0;
      sb_w     <= '0;
      rk_valid <= 1'b0;
      rk_idx   <= '0;
      rk_data  <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      w        <= w_nxt;
      round    <= round_nxt;
      rcon     <= rcon_nxt;
      cnt      <= cnt_nxt;
      sb_q     <= sb_q_nxt;
      busy     <= busy_nxt;
      sb_start <= sb_start_nxt;
      sb_w     <= sb_w_nxt;
      rk_valid <= rk_valid_nxt;
      rk_idx   <= rk_idx_nxt;
      rk_data  <= rk_data_nxt;
      done     <= done_nxt;
    end
  end

`ifdef AES_KEY_EXP_STORE_EN
  logic [127:0] store [0:10];

  // Written from the registered rk outputs, so a same-cycle read sees the old entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 11; i++) store[i] <= '0;
      rk_rd_data <= '0;
    end else begin
      if (rk_valid && (rk_idx <= 4'd10)) store[rk_idx] <= rk_data;
      rk_rd_data <= (rk_rd_idx <= 4'd10) ? store[rk_rd_idx] : '0;
    end
  end
`endif

endmodule
